banco_registros_wb: RTL

- Write-back stage and register file for the MIPS datapath; sits directly downstream of the write-destination mux and consumes its 5-bit `dir_wr`.
- A WB pipeline latch captures destination, data and write enable; on the following edge it commits the data into a 32x32 register array.
- Two combinational read ports (rs/rt) feed decode and forward the pending WB-latch value. Register 0 is hardwired to zero.
- A write counter supports debug/DMA status.

---
 rtl/banco_registros_wb.sv | 91 +++++++++
 1 files changed

// File: rtl/banco_registros_wb.sv
// Write-back latch and 32-entry register file with two forwarding read ports.
// Register 0 reads as zero; committed writes are counted for debug/DMA status.
module banco_registros_wb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] dir_wr,
  input  logic [DATA_W-1:0] dato_wr,
  input  logic              reg_write,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] dato_rs,
  output logic [DATA_W-1:0] dato_rt,
  output logic              wb_pendiente,
  output logic [CNT_W-1:0]  num_escrituras
);

  localparam int unsigned     DEPTH = 2**ADDR_W;
  localparam logic [CNT_W-1:0] UNO  = 1;

  logic [DATA_W-1:0] regs [0:DEPTH-1];
  logic              wb_we;
  logic [ADDR_W-1:0] wb_dir;
  logic [DATA_W-1:0] wb_dato;
  logic [CNT_W-1:0]  cnt;
  logic              commit;

  // flush squashes both the write already latched and the one being captured
  assign commit = wb_we & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we   <= 1'b0;
      wb_dir  <= '0;
      wb_dato <= '0;
    end else if (flush || stall) begin
      wb_we   <= 1'b0;
      wb_dir  <= '0;
      wb_dato <= '0;
    end else begin
      wb_we   <= reg_write && (dir_wr != '0);
      wb_dir  <= dir_wr;
      wb_dato <= dato_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[wb_dir] <= wb_dato;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (commit) begin
      cnt <= cnt + UNO;
    end
  end

  always_comb begin
    dato_rs = regs[rs];
    if (rs == '0) begin
      dato_rs = '0;
    end else if (wb_we && (wb_dir == rs)) begin
      dato_rs = wb_dato;
    end
  end

  always_comb begin
    dato_rt = regs[rt];
    if (rt == '0) begin
      dato_rt = '0;
    end else if (wb_we && (wb_dir == rt)) begin
      dato_rt = wb_dato;
    end
  end

  assign wb_pendiente   = wb_we;
  assign num_escrituras = cnt;

endmodule
